// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one combinational 32-bit ALU between
// two requesters, with registered operands, a multicycle MUL hold and a tagged response.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_carry,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        busy
);

  localparam int unsigned MUL_E = (MUL_CYCLES == 32'd0) ? 32'd1 : MUL_CYCLES;
  localparam int unsigned CW = (MUL_E < 32'd2) ? 32'd1 : $clog2(MUL_E + 32'd1);
  localparam logic [2:0] SEL_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          last_grant_r;
  logic          grant_s, accept_s, exec_done_s, rsp_hs_s;
  logic [CW-1:0] cnt_r, cnt_load_s;
  logic [31:0]   op_a_r, op_b_r;
  logic [2:0]    op_sel_r;
  logic          rsp_valid_r, rsp_id_r;
  logic [31:0]   rsp_result_r;
  logic [3:0]    rsp_flags_r;

  // Grant selection; readies are suppressed while reset is asserted
  always_comb begin
    grant_s    = 1'b0;
    accept_s   = 1'b0;
    cnt_load_s = CW'(1'b1);
    if (req0_valid && req1_valid) grant_s = ~last_grant_r;
    else if (req1_valid)          grant_s = 1'b1;
    else                          grant_s = 1'b0;
    if (rst_n && (state_r == IDLE) && (req0_valid || req1_valid)) accept_s = 1'b1;
    else                                                           accept_s = 1'b0;
    if ((grant_s ? req1_sel : req0_sel) == SEL_MUL) cnt_load_s = CW'(MUL_E);
    else                                            cnt_load_s = CW'(1'b1);
  end

  assign exec_done_s = (state_r == EXEC) && (cnt_r == CW'(1'b1));
  assign rsp_hs_s    = rsp_valid_r && rsp_ready;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s)    state_s = EXEC; else state_s = IDLE;
      EXEC:    if (exec_done_s) state_s = RESP; else state_s = EXEC;
      RESP:    if (rsp_hs_s)    state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // State, operand capture, hold counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= '0;
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      op_sel_r     <= 3'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_flags_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_a_r       <= grant_s ? req1_a : req0_a;
        op_b_r       <= grant_s ? req1_b : req0_b;
        op_sel_r     <= grant_s ? req1_sel : req0_sel;
        rsp_id_r     <= grant_s;
        last_grant_r <= grant_s;
        cnt_r        <= cnt_load_s;
      end else if (state_r == EXEC) begin
        cnt_r <= cnt_r - CW'(1'b1);
      end
      // Response fields only change when a new result is sampled
      if (exec_done_s) begin
        rsp_result_r <= alu_out;
        rsp_flags_r  <= {alu_ovf, alu_carry, alu_neg, alu_zero};
        rsp_valid_r  <= 1'b1;
      end else if (rsp_hs_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign req0_ready = accept_s && !grant_s;
  assign req1_ready = accept_s && grant_s;
  assign alu_a      = op_a_r;
  assign alu_b      = op_b_r;
  assign alu_sel    = op_sel_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test-plan scenarios plus randomized traffic, checked
// against a transaction-level model of arbitration, latency and ALU results.
module tb_alu_arbiter;
  localparam int unsigned MUL_CYCLES = 3;
  localparam int MUL_E = (MUL_CYCLES == 0) ? 1 : MUL_CYCLES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [2:0]  req0_sel = 3'd0, req1_sel = 3'd0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_zero, alu_neg, alu_carry, alu_ovf;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int n_checks = 0;
  int n_fail = 0;

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {ovf, carry, neg, zero, result}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, o;
    wide = 33'd0; r = 32'd0; c = 1'b0; o = 1'b0;
    case (sel)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b011: r = a << b[4:0];
      3'b100: begin
        wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b101: begin
        wide = {1'b0, a} - {1'b0, b}; r = wide[31:0]; c = wide[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b110: r = a * b;
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {o, c, r[31], (r == 32'd0), r};
  endfunction

  assign {alu_ovf, alu_carry, alu_neg, alu_zero, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model state
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [3:0]  fl;
    int          due;
  } exp_t;
  exp_t        pend[$];
  int          cyc = 0;
  bit          model_free = 1'b1;
  bit          last = 1'b1;
  logic [31:0] cap_a = 32'd0, cap_b = 32'd0;
  logic [2:0]  cap_sel = 3'd0;
  bit          acc0, acc1, hs;
  bit          seen_valid, seen_id;
  logic [31:0] seen_result;
  logic [3:0]  seen_flags;

  // One clock cycle: check outputs at the falling edge, update the model, advance
  task automatic step();
    bit          v0, v1, g, want, exp_v;
    logic [35:0] r;
    exp_t        e;
    @(negedge clk);
    v0 = req0_valid; v1 = req1_valid;
    want = model_free && (v0 || v1);
    g = (v0 && v1) ? ~last : v1;
    check_eq("ready0", req0_ready, want && !g);
    check_eq("ready1", req1_ready, want && g);
    check_eq("busy", busy, !model_free);
    check_eq("alu_a", alu_a, cap_a);
    check_eq("alu_b", alu_b, cap_b);
    check_eq("alu_sel", alu_sel, cap_sel);
    exp_v = (pend.size() > 0) && (cyc >= pend[0].due);
    check_eq("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      check_eq("rsp_id", rsp_id, pend[0].id);
      check_eq("rsp_result", rsp_result, pend[0].res);
      check_eq("rsp_flags", rsp_flags, pend[0].fl);
    end
    seen_valid = rsp_valid; seen_id = rsp_id; seen_result = rsp_result; seen_flags = rsp_flags;
    acc0 = want && !g;
    acc1 = want && g;
    hs = exp_v && rsp_ready;
    if (hs) begin
      void'(pend.pop_front());
      model_free = 1'b1;
    end
    if (acc0 || acc1) begin
      cap_a   = g ? req1_a : req0_a;
      cap_b   = g ? req1_b : req0_b;
      cap_sel = g ? req1_sel : req0_sel;
      r = alu_ref(cap_a, cap_b, cap_sel);
      e.id = g; e.res = r[31:0]; e.fl = r[35:32];
      e.due = cyc + 1 + ((cap_sel == 3'b110) ? MUL_E : 1);
      pend.push_back(e);
      model_free = 1'b0;
      last = g;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_alu", {alu_a, alu_b[28:0], alu_sel}, 64'd0);
    check_eq("rst_rsp", {rsp_id, rsp_flags, rsp_result}, 64'd0);
    pend.delete();
    model_free = 1'b1; last = 1'b1;
    cap_a = 32'd0; cap_b = 32'd0; cap_sel = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input bit n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    if (n) begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; end
    else   begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin step(); n++; end while (!seen_valid && n < 20);
  endtask

  int lat;
  int grants[$];

  initial begin
    do_reset();

    // ADD 5+7 from requester 0
    set_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b100);
    step();
    check_eq("add_accept", acc0, 1'b1);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    wait_rsp(lat);
    check_eq("add_latency", lat, 2);
    check_eq("add_result", seen_result, 32'd12);
    check_eq("add_flags", seen_flags, 4'b0000);
    check_eq("add_id", seen_id, 1'b0);
    step();

    // Tie from reset: alternating grants
    do_reset();
    set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b100);
    set_req(1'b1, 1'b1, 32'd3, 32'd4, 3'b101);
    for (int i = 0; i < 20 && grants.size() < 4; i++) begin
      step();
      if (acc0) begin grants.push_back(0); set_req(1'b0, 1'b1, $urandom, $urandom, 3'b100); end
      if (acc1) begin grants.push_back(1); set_req(1'b1, 1'b1, $urandom, $urandom, 3'b101); end
    end
    check_eq("rr_count", grants.size(), 4);
    foreach (grants[i]) check_eq("rr_order", grants[i], i % 2);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) step();

    // Signed overflow, then SUB to zero
    set_req(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 3'b100);
    step();
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    wait_rsp(lat);
    check_eq("ovf_result", seen_result, 32'h8000_0000);
    check_eq("ovf_flags", seen_flags, 4'b1010);
    check_eq("ovf_id", seen_id, 1'b1);
    step();
    set_req(1'b1, 1'b1, 32'h1234, 32'h1234, 3'b101);
    step();
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    wait_rsp(lat);
    check_eq("sub_result", seen_result, 32'd0);
    check_eq("sub_zero", seen_flags[0], 1'b1);
    step();

    // Multicycle MUL hold
    set_req(1'b0, 1'b1, 32'd6, 32'hFFFF_FFF9, 3'b110);
    step();
    check_eq("mul_accept", acc0, 1'b1);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    lat = 0;
    do begin
      step(); lat++;
      if (!seen_valid) check_eq("mul_sel_hold", alu_sel, 3'b110);
    end while (!seen_valid && lat < 20);
    check_eq("mul_latency", lat, 1 + MUL_E);
    check_eq("mul_result", seen_result, 32'hFFFF_FFD6);
    check_eq("mul_neg", seen_flags[1], 1'b1);
    step();

    // Response backpressure with a waiting requester
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd9, 32'd3, 3'b101);
    step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b1, 32'd100, 32'd23, 3'b100);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_no_accept", acc1, 1'b0);
      check_eq("bp_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_handshake", hs, 1'b1);
    step();
    check_eq("bp_accept_next", acc1, 1'b1);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) step();

    // Reset during a MUL execution
    set_req(1'b1, 1'b1, 32'd11, 32'd13, 3'b110);
    step();
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    step();
    do_reset();
    set_req(1'b0, 1'b1, 32'd20, 32'd22, 3'b100);
    set_req(1'b1, 1'b1, 32'd30, 32'd33, 3'b100);
    step();
    check_eq("rst_tie_req0", acc0, 1'b1);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (acc0 || !req0_valid)
        set_req(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)));
      if (acc1 || !req1_valid)
        set_req(1'b1, ($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
